// File: rtl/output_process_uart_if.sv
// Byte-stream transmit bus: message-word write side plus UART transmitter byte handshake.
// The master drives words and tx_ready; the slave (output_process_uart) serialises them.
interface output_process_uart_if #(
    parameter int DEPTH_LOG2 = 7
);
    logic                  wr_req;
    logic [15:0]           data_in;
    logic                  last_in;
    logic                  odd_in;
    logic                  full;
    logic [DEPTH_LOG2:0]   used_w;
    logic                  overflow;
    logic                  busy;
    logic                  msg_sent;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    modport master (
        output wr_req, data_in, last_in, odd_in, tx_ready,
        input  full, used_w, overflow, busy, msg_sent, tx_data, tx_valid
    );

    modport slave (
        input  wr_req, data_in, last_in, odd_in, tx_ready,
        output full, used_w, overflow, busy, msg_sent, tx_data, tx_valid
    );
endinterface

// File: rtl/output_process_uart.sv
// Word FIFO plus byte serialiser (high byte first) onto the UART transmitter handshake.
// Optional post-message idle gap is built only when UART_TX_GAP_EN is defined.
//
// state  | meaning
// S_IDLE | waiting for a word in the FIFO; pops it into the holding register
// S_HI   | presenting high byte of the held word
// S_LO   | presenting low byte of the held word
// S_DONE | one-cycle MSG_SENT pulse after the final byte of a message
// S_GAP  | GAP_CYCLES of forced silence after a message (UART_TX_GAP_EN only)
module output_process_uart #(
    parameter int DEPTH_LOG2 = 7,
    parameter int GAP_CYCLES = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    output_process_uart_if.slave  bus
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

`ifdef UART_TX_GAP_EN
    typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_DONE, S_GAP} state_t;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    logic [GW-1:0] r_gap_cnt;
`else
    typedef enum logic [1:0] {S_IDLE, S_HI, S_LO, S_DONE} state_t;
`endif

    logic [17:0]           r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_used;
    logic                  r_full;
    logic                  r_overflow;
    logic [17:0]           r_hold;
    state_t                r_state;
    state_t                w_next;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_empty;
    logic                  w_tx_valid;
    logic [7:0]            w_tx_data;
    logic                  w_msg_sent;

    assign w_push  = bus.wr_req & ~r_full;
    assign w_empty = (r_used == '0);

    // Entry layout {last, odd, data}; odd is only meaningful on the last word.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.last_in, bus.last_in & bus.odd_in, bus.data_in};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_used     <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
            r_hold     <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_hold   <= r_mem[r_rd_ptr];
            end
            if (w_push && !w_pop) begin
                r_used <= r_used + 1'b1;
                r_full <= (r_used == (DEPTH_LOG2+1)'(DEPTH - 1));
            end else if (w_pop && !w_push) begin
                r_used <= r_used - 1'b1;
                r_full <= 1'b0;
            end
            if (bus.wr_req && r_full) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

`ifdef UART_TX_GAP_EN
    // Reloaded on every DONE so each gap is a full GAP_CYCLES long.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gap_cnt <= '0;
        end else if (r_state == S_DONE) begin
            r_gap_cnt <= GW'(GAP_CYCLES - 1);
        end else if (r_state == S_GAP && r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
        end
    end
`endif

    always_comb begin
        w_next     = r_state;
        w_pop      = 1'b0;
        w_tx_valid = 1'b0;
        w_tx_data  = 8'h00;
        w_msg_sent = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = S_HI;
                end
            end
            S_HI: begin
                w_tx_valid = 1'b1;
                w_tx_data  = r_hold[15:8];
                if (bus.tx_ready) w_next = (r_hold[17] && r_hold[16]) ? S_DONE : S_LO;
            end
            S_LO: begin
                w_tx_valid = 1'b1;
                w_tx_data  = r_hold[7:0];
                if (bus.tx_ready) begin
                    if (r_hold[17]) begin
                        w_next = S_DONE;
                    end else if (!w_empty) begin
                        w_pop  = 1'b1;
                        w_next = S_HI;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            S_DONE: begin
                w_msg_sent = 1'b1;
`ifdef UART_TX_GAP_EN
                w_next     = S_GAP;
`else
                w_next     = S_IDLE;
`endif
            end
`ifdef UART_TX_GAP_EN
            S_GAP: begin
                if (r_gap_cnt == '0) w_next = S_IDLE;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.tx_valid = w_tx_valid;
    assign bus.tx_data  = w_tx_data;
    assign bus.msg_sent = w_msg_sent;
    assign bus.full     = r_full;
    assign bus.used_w   = r_used;
    assign bus.overflow = r_overflow;
    assign bus.busy     = (r_state != S_IDLE) || !w_empty;
endmodule

// File: tb/tb_output_process_uart.sv
// Directed + randomized bench for output_process_uart; expected byte streams come from
// a word-level model (high byte, then low byte unless last & odd).
module tb_output_process_uart;
    localparam int DL     = 7;
    localparam int TB_GAP = 4;
`ifdef UART_TX_GAP_EN
    localparam int EXP_IDLE = 2 + TB_GAP;
`else
    localparam int EXP_IDLE = 2;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    output_process_uart_if #(.DEPTH_LOG2(DL)) bus ();

    output_process_uart #(.DEPTH_LOG2(DL), .GAP_CYCLES(TB_GAP)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int got_q[$];
    int got_c[$];
    int msg_c[$];
    int wr_c[$];
    int exp_q[$];
    bit rand_ready = 1'b0;
    bit stall      = 1'b0;
    int stall_data = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Monitor: records transfers, MSG_SENT pulses and accepted writes by cycle number.
    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.tx_valid && bus.tx_ready) begin
                got_q.push_back(int'(bus.tx_data));
                got_c.push_back(cyc);
            end
            if (bus.msg_sent) msg_c.push_back(cyc);
            if (bus.wr_req && !bus.full) wr_c.push_back(cyc);
            stall      = bus.tx_valid && !bus.tx_ready;
            stall_data = int'(bus.tx_data);
        end else begin
            stall = 1'b0;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (rst_n && stall) begin
            chk("stall_valid", bus.tx_valid, 1);
            chk("stall_data", bus.tx_data, stall_data);
        end
        if (rand_ready) bus.tx_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic clear_logs();
        got_q.delete(); got_c.delete(); msg_c.delete(); wr_c.delete(); exp_q.delete();
    endtask

    task automatic model_add(input logic [15:0] d, input logic last, input logic odd);
        exp_q.push_back(int'(d[15:8]));
        if (!(last && odd)) exp_q.push_back(int'(d[7:0]));
    endtask

    task automatic write_word(input logic [15:0] d, input logic last, input logic odd);
        bus.wr_req  = 1'b1;
        bus.data_in = d;
        bus.last_in = last;
        bus.odd_in  = odd;
        @(negedge clk);
    endtask

    task automatic write_end();
        bus.wr_req  = 1'b0;
        bus.last_in = 1'b0;
        bus.odd_in  = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget, input string tag);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, got_q.size() >= n, 1);
    endtask

    task automatic cmp_stream(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk({tag, "_byte"}, got_q[i], exp_q[i]);
        end
    endtask

    initial begin
        logic [15:0] d;
        int nw;
        logic o;

        bus.wr_req = 1'b0; bus.data_in = '0; bus.last_in = 1'b0; bus.odd_in = 1'b0;
        bus.tx_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_valid", bus.tx_valid, 0);
        chk("rst_data", bus.tx_data, 0);
        chk("rst_used", bus.used_w, 0);
        chk("rst_full", bus.full, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_msg", bus.msg_sent, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single even word: A5 then 5A, MSG_SENT the cycle after
        clear_logs();
        bus.tx_ready = 1'b1;
        write_word(16'hA55A, 1'b1, 1'b0);
        write_end();
        model_add(16'hA55A, 1'b1, 1'b0);
        wait_bytes(2, 20, "t2_timeout");
        repeat (3) @(negedge clk);
        cmp_stream("t2");
        chk("t2_latency", qat(got_c, 0) - qat(wr_c, 0), 2);
        chk("t2_b2b", qat(got_c, 1) - qat(got_c, 0), 1);
        chk("t2_msg_count", msg_c.size(), 1);
        chk("t2_msg_cycle", qat(msg_c, 0), qat(got_c, 1) + 1);

        // Odd-length message: stuffing byte FF never sent
        clear_logs();
        write_word(16'h1234, 1'b0, 1'b0);
        write_word(16'h56FF, 1'b1, 1'b1);
        write_end();
        model_add(16'h1234, 1'b0, 1'b0);
        model_add(16'h56FF, 1'b1, 1'b1);
        wait_bytes(3, 30, "t3_timeout");
        repeat (10) @(negedge clk);
        cmp_stream("t3");
        chk("t3_msg_count", msg_c.size(), 1);

        // Backpressure: A5 held stable for 10 cycles
        clear_logs();
        bus.tx_ready = 1'b0;
        write_word(16'hA55A, 1'b1, 1'b0);
        write_end();
        model_add(16'hA55A, 1'b1, 1'b0);
        for (int k = 0; k < 10 && !bus.tx_valid; k++) @(negedge clk);
        chk("t4_valid_up", bus.tx_valid, 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t4_hold_valid", bus.tx_valid, 1);
            chk("t4_hold_data", bus.tx_data, 8'hA5);
        end
        bus.tx_ready = 1'b1;
        wait_bytes(2, 20, "t4_timeout");
        repeat (3) @(negedge clk);
        cmp_stream("t4");

        // Two queued 1-word messages: idle cycles between them
        clear_logs();
        write_word(16'h1111, 1'b1, 1'b0);
        write_word(16'h2222, 1'b1, 1'b0);
        write_end();
        model_add(16'h1111, 1'b1, 1'b0);
        model_add(16'h2222, 1'b1, 1'b0);
        wait_bytes(4, 80, "t6_timeout");
        repeat (TB_GAP + 4) @(negedge clk);
        cmp_stream("t6");
        chk("t6_idle_cycles", qat(got_c, 2) - qat(got_c, 1) - 1, EXP_IDLE);
        chk("t6_msg_count", msg_c.size(), 2);

        // Fill to overflow: 1 in HOLD, 128 in FIFO, word 130 lost
        clear_logs();
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 130; i++) begin
            d = 16'($urandom);
            write_word(d, (i == 128), 1'b0);
            if (i <= 128) model_add(d, (i == 128), 1'b0);
        end
        write_end();
        repeat (2) @(negedge clk);
        chk("t5_used", bus.used_w, 128);
        chk("t5_full", bus.full, 1);
        chk("t5_ovf", bus.overflow, 1);
        chk("t5_busy", bus.busy, 1);
        chk("t5_accepted", wr_c.size(), 129);
        bus.tx_ready = 1'b1;
        wait_bytes(258, 600, "t5_timeout");
        repeat (5) @(negedge clk);
        cmp_stream("t5");
        chk("t5_used_drained", bus.used_w, 0);
        chk("t5_full_drained", bus.full, 0);
        chk("t5_ovf_sticky", bus.overflow, 1);
        chk("t5_msg_count", msg_c.size(), 1);

        // Random messages with random backpressure and write gaps
        clear_logs();
        rand_ready = 1'b1;
        for (int m = 0; m < 6; m++) begin
            nw = $urandom_range(1, 4);
            o  = 1'($urandom);
            for (int w = 0; w < nw; w++) begin
                d = 16'($urandom);
                write_word(d, (w == nw - 1), (w == nw - 1) ? o : 1'($urandom));
                model_add(d, (w == nw - 1), (w == nw - 1) && o);
                if ($urandom_range(0, 2) == 0) begin
                    write_end();
                    @(negedge clk);
                end
            end
        end
        write_end();
        wait_bytes(exp_q.size(), 2000, "t7_timeout");
        rand_ready = 1'b0;
        bus.tx_ready = 1'b1;
        repeat (5) @(negedge clk);
        cmp_stream("t7");
        chk("t7_msg_count", msg_c.size(), 6);
        chk("t7_busy_idle", bus.busy, 0);

        // Reset mid-byte: everything cleared, no partial byte resumed
        clear_logs();
        bus.tx_ready = 1'b0;
        write_word(16'hBEEF, 1'b1, 1'b0);
        write_word(16'hCAFE, 1'b1, 1'b0);
        write_end();
        for (int k = 0; k < 10 && !bus.tx_valid; k++) @(negedge clk);
        chk("t1_valid_before", bus.tx_valid, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_valid", bus.tx_valid, 0);
        chk("t1_data", bus.tx_data, 0);
        chk("t1_used", bus.used_w, 0);
        chk("t1_ovf", bus.overflow, 0);
        chk("t1_msg", bus.msg_sent, 0);
        chk("t1_full", bus.full, 0);
        chk("t1_busy", bus.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.tx_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("t1_no_resume", got_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
